// File: rtl/ram_pkg.sv
// Shared definitions for the RAM request arbiters: grant-index sizing, grant
// codes and the strobe encoding the memory controller also decodes.
package ram_pkg;

    function automatic int clog2p1(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int GRANT_PRI = 0;

    typedef enum logic [1:0] {
        STB_NONE = 2'b00,
        STB_RD   = 2'b01,
        STB_WR   = 2'b10
    } stb_e;

endpackage

// File: rtl/ram_rr_pick.sv
// Combinational round-robin picker: returns the first set bit of pend at or
// after ptr, wrapping modulo N.
module ram_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     pend,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N) s = s - N;
        return IDX_W'(s);
    endfunction

    // Walk from the farthest offset back to ptr so the nearest pending port wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (pend[wrap_add(ptr, k)]) begin
                valid = 1'b1;
                idx   = wrap_add(ptr, k);
            end
        end
    end

endmodule

// File: rtl/ram_request_arbiter.sv
// Arbitrates a level-request priority port and N_SEC toggle-request read ports
// onto one registered strobe interface, all in the clk_memory domain.
module ram_request_arbiter
    import ram_pkg::*;
#(
    parameter int ADDR_W           = 21,
    parameter int DATA_W           = 8,
    parameter int N_SEC            = 2,
    parameter int SYNC_STAGES      = 2,
    parameter int BLOCK_SEC_ON_PRI = 1
) (
    input  logic                      clk_memory,
    input  logic                      reset,
    input  logic                      pri_req,
    input  logic                      pri_rd_n,
    input  logic [ADDR_W-1:0]         pri_addr,
    input  logic [DATA_W-1:0]         pri_wdata,
    input  logic [N_SEC-1:0]          sec_req_t,
    input  logic [N_SEC*ADDR_W-1:0]   sec_addr,
    input  logic                      mem_ready,
    output logic                      mem_we,
    output logic                      mem_re,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic [clog2p1(N_SEC)-1:0] mem_grant,
    output logic [N_SEC-1:0]          sec_ack_t
);

    localparam int GW    = clog2p1(N_SEC);
    localparam int IDX_W = (N_SEC > 1) ? $clog2(N_SEC) : 1;

    logic                    pri_req_q, pri_req_qq, pri_rd_n_q;
    logic [ADDR_W-1:0]       pri_addr_q;
    logic [DATA_W-1:0]       pri_wdata_q;
    logic [N_SEC*ADDR_W-1:0] sec_addr_q;
    (* ASYNC_REG = "TRUE" *) logic [N_SEC-1:0] sec_req_cap_q;
    logic [N_SEC-1:0]        sync_req_t;

    always_ff @(posedge clk_memory or posedge reset) begin
        if (reset) begin
            pri_req_q     <= 1'b0;
            pri_req_qq    <= 1'b0;
            pri_rd_n_q    <= 1'b0;
            pri_addr_q    <= '0;
            pri_wdata_q   <= '0;
            sec_addr_q    <= '0;
            sec_req_cap_q <= '0;
        end else begin
            pri_req_q     <= pri_req;
            pri_req_qq    <= pri_req_q;
            pri_rd_n_q    <= pri_rd_n;
            pri_addr_q    <= pri_addr;
            pri_wdata_q   <= pri_wdata;
            sec_addr_q    <= sec_addr;
            sec_req_cap_q <= sec_req_t;
        end
    end

    // The toggle is sampled with the other inputs, then resolved through SYNC_STAGES flops.
    for (genvar g = 0; g < N_SEC; g++) begin : g_sync
        (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
        always_ff @(posedge clk_memory or posedge reset) begin
            if (reset) sync_q <= '0;
            else       sync_q <= (sync_q << 1) | SYNC_STAGES'(sec_req_cap_q[g]);
        end
        assign sync_req_t[g] = sync_q[SYNC_STAGES-1];
    end

    logic                    pri_pend_q, pri_pend_d;
    logic                    hold_rd_n_q, hold_rd_n_d;
    logic [ADDR_W-1:0]       hold_addr_q, hold_addr_d;
    logic [DATA_W-1:0]       hold_wdata_q, hold_wdata_d;
    logic [N_SEC-1:0]        seen_q, seen_d;
    logic [IDX_W-1:0]        rr_q, rr_d;
    stb_e                    iss_stb_q, iss_stb_d;
    logic [ADDR_W-1:0]       iss_addr_q, iss_addr_d;
    logic [DATA_W-1:0]       iss_wdata_q, iss_wdata_d;
    logic [GW-1:0]           iss_grant_q, iss_grant_d;
    logic [N_SEC-1:0]        iss_ack_q, iss_ack_d;
    logic                    mem_we_q, mem_we_d, mem_re_q, mem_re_d;
    logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]       mem_wdata_q, mem_wdata_d;
    logic [GW-1:0]           mem_grant_q, mem_grant_d;
    logic [N_SEC-1:0]        sec_ack_q, sec_ack_d;

    logic                    pri_rise, sec_allow, sec_valid;
    logic [N_SEC-1:0]        sec_pend;
    logic [IDX_W-1:0]        sec_idx;
    logic [ADDR_W-1:0]       sec_sel_addr;

    assign pri_rise  = pri_req_q & ~pri_req_qq;
    assign sec_allow = (BLOCK_SEC_ON_PRI == 0) || !pri_req_q;
    assign sec_pend  = (sync_req_t ^ seen_q) & {N_SEC{sec_allow}};

    ram_rr_pick #(
        .N     (N_SEC),
        .IDX_W (IDX_W)
    ) u_pick (
        .pend  (sec_pend),
        .ptr   (rr_q),
        .valid (sec_valid),
        .idx   (sec_idx)
    );

    always_comb begin
        sec_sel_addr = '0;
        for (int i = 0; i < N_SEC; i++) begin
            if (sec_idx == IDX_W'(i)) sec_sel_addr = sec_addr_q[i*ADDR_W +: ADDR_W];
        end
    end

    // Issue decision; registered into the iss_* stage, strobed out one edge later.
    always_comb begin
        pri_pend_d   = pri_pend_q;
        hold_rd_n_d  = hold_rd_n_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        seen_d       = seen_q;
        rr_d         = rr_q;
        iss_stb_d    = STB_NONE;
        iss_addr_d   = iss_addr_q;
        iss_wdata_d  = iss_wdata_q;
        iss_grant_d  = iss_grant_q;
        iss_ack_d    = '0;
        if (mem_ready && pri_pend_q) begin
            iss_stb_d   = hold_rd_n_q ? STB_WR : STB_RD;
            iss_addr_d  = hold_addr_q;
            iss_wdata_d = hold_rd_n_q ? hold_wdata_q : '0;
            iss_grant_d = GW'(GRANT_PRI);
            pri_pend_d  = 1'b0;
        end else if (mem_ready && sec_valid) begin
            iss_stb_d   = STB_RD;
            iss_addr_d  = sec_sel_addr;
            iss_wdata_d = '0;
            iss_grant_d = GW'(sec_idx) + GW'(1);
            for (int i = 0; i < N_SEC; i++) begin
                if (sec_idx == IDX_W'(i)) begin
                    seen_d[i]    = sync_req_t[i];
                    iss_ack_d[i] = 1'b1;
                end
            end
            rr_d = (sec_idx == IDX_W'(N_SEC - 1)) ? '0 : sec_idx + IDX_W'(1);
        end
        // A new edge while still pending just refreshes the held access.
        if (pri_rise) begin
            pri_pend_d   = 1'b1;
            hold_rd_n_d  = pri_rd_n_q;
            hold_addr_d  = pri_addr_q;
            hold_wdata_d = pri_wdata_q;
        end
    end

    always_comb begin
        mem_we_d    = (iss_stb_q == STB_WR);
        mem_re_d    = (iss_stb_q == STB_RD);
        mem_addr_d  = (iss_stb_q != STB_NONE) ? iss_addr_q  : mem_addr_q;
        mem_wdata_d = (iss_stb_q != STB_NONE) ? iss_wdata_q : mem_wdata_q;
        mem_grant_d = (iss_stb_q != STB_NONE) ? iss_grant_q : mem_grant_q;
        sec_ack_d   = sec_ack_q ^ iss_ack_q;
    end

    always_ff @(posedge clk_memory or posedge reset) begin
        if (reset) begin
            pri_pend_q   <= 1'b0;
            hold_rd_n_q  <= 1'b0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
            seen_q       <= '0;
            rr_q         <= '0;
            iss_stb_q    <= STB_NONE;
            iss_addr_q   <= '0;
            iss_wdata_q  <= '0;
            iss_grant_q  <= '0;
            iss_ack_q    <= '0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_grant_q  <= '0;
            sec_ack_q    <= '0;
        end else begin
            pri_pend_q   <= pri_pend_d;
            hold_rd_n_q  <= hold_rd_n_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            seen_q       <= seen_d;
            rr_q         <= rr_d;
            iss_stb_q    <= iss_stb_d;
            iss_addr_q   <= iss_addr_d;
            iss_wdata_q  <= iss_wdata_d;
            iss_grant_q  <= iss_grant_d;
            iss_ack_q    <= iss_ack_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_grant_q  <= mem_grant_d;
            sec_ack_q    <= sec_ack_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_grant = mem_grant_q;
    assign sec_ack_t = sec_ack_q;

endmodule

// File: tb/tb_ram_request_arbiter.sv
// Directed bench for ram_request_arbiter with default parameters
// (N_SEC=2, SYNC_STAGES=2, BLOCK_SEC_ON_PRI=1).
module tb_ram_request_arbiter;

    logic        clk_memory = 1'b0;
    logic        reset;
    logic        pri_req;
    logic        pri_rd_n;
    logic [20:0] pri_addr;
    logic [7:0]  pri_wdata;
    logic [1:0]  sec_req_t;
    logic [41:0] sec_addr;
    logic        mem_ready;
    logic        mem_we;
    logic        mem_re;
    logic [20:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [1:0]  mem_grant;
    logic [1:0]  sec_ack_t;

    int total = 0;
    int bad   = 0;

    ram_request_arbiter dut (
        .clk_memory (clk_memory),
        .reset      (reset),
        .pri_req    (pri_req),
        .pri_rd_n   (pri_rd_n),
        .pri_addr   (pri_addr),
        .pri_wdata  (pri_wdata),
        .sec_req_t  (sec_req_t),
        .sec_addr   (sec_addr),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_grant  (mem_grant),
        .sec_ack_t  (sec_ack_t)
    );

    always #5 clk_memory = ~clk_memory;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_memory);
        #1;
    endtask

    task automatic idle_steps(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step();
            chk(tag, {mem_we, mem_re}, 2'b00);
        end
    endtask

    task automatic expect_strobe(input string tag, input logic we, input logic re,
                                 input logic [20:0] addr, input logic [7:0] wdata,
                                 input logic [1:0] grant, input logic [1:0] ack);
        chk({tag, ".we"},    mem_we,    we);
        chk({tag, ".re"},    mem_re,    re);
        chk({tag, ".addr"},  mem_addr,  addr);
        chk({tag, ".wdata"}, mem_wdata, wdata);
        chk({tag, ".grant"}, mem_grant, grant);
        chk({tag, ".ack"},   sec_ack_t, ack);
    endtask

    initial begin
        logic [1:0] exp_g;
        int         n_grants;
        logic       found;

        reset     = 1'b1;
        pri_req   = 1'b0;
        pri_rd_n  = 1'b0;
        pri_addr  = '0;
        pri_wdata = '0;
        sec_req_t = 2'b00;
        sec_addr  = '0;
        mem_ready = 1'b1;
        step();
        step();
        expect_strobe("reset", 1'b0, 1'b0, 21'h0, 8'h00, 2'd0, 2'b00);
        reset = 1'b0;
        idle_steps(2, "t0_idle");

        // 1: priority write, strobe on the third edge after the first sample
        pri_req   = 1'b1;
        pri_rd_n  = 1'b1;
        pri_addr  = 21'h01234;
        pri_wdata = 8'hA5;
        idle_steps(3, "t1_lat");
        step();
        expect_strobe("t1_wr", 1'b1, 1'b0, 21'h01234, 8'hA5, 2'd0, 2'b00);
        idle_steps(5, "t1_single");
        chk("t1_addr_hold", mem_addr, 21'h01234);
        pri_req = 1'b0;
        idle_steps(2, "t1_fall");

        // 2: both secondaries toggle together; port 0 then port 1
        sec_addr  = {21'h00200, 21'h00100};
        sec_req_t = 2'b11;
        idle_steps(4, "t2_lat");
        step();
        expect_strobe("t2_p0", 1'b0, 1'b1, 21'h00100, 8'h00, 2'd1, 2'b01);
        step();
        expect_strobe("t2_p1", 1'b0, 1'b1, 21'h00200, 8'h00, 2'd2, 2'b11);
        idle_steps(1, "t2_after");
        chk("t2_addr_hold", mem_addr, 21'h00200);

        // 3: priority read, then secondary 0 blocked while pri_req stays high
        pri_req   = 1'b1;
        pri_rd_n  = 1'b0;
        pri_addr  = 21'h0ABCD;
        pri_wdata = 8'h5A;
        sec_req_t = 2'b10;
        idle_steps(3, "t3_lat");
        step();
        expect_strobe("t3_pri", 1'b0, 1'b1, 21'h0ABCD, 8'h00, 2'd0, 2'b11);
        idle_steps(6, "t3_blocked");
        pri_req = 1'b0;
        idle_steps(2, "t3_unblock");
        step();
        expect_strobe("t3_sec", 1'b0, 1'b1, 21'h00100, 8'h00, 2'd1, 2'b10);

        // 3b: pointer now at port 1, so a simultaneous pair starts with port 1
        sec_req_t = 2'b01;
        idle_steps(4, "t3b_lat");
        step();
        expect_strobe("t3b_p1", 1'b0, 1'b1, 21'h00200, 8'h00, 2'd2, 2'b00);
        step();
        expect_strobe("t3b_p0", 1'b0, 1'b1, 21'h00100, 8'h00, 2'd1, 2'b01);
        idle_steps(1, "t3b_after");

        // 4: mem_ready low for 5 cycles with priority read and port 1 pending
        mem_ready = 1'b0;
        pri_req   = 1'b1;
        pri_rd_n  = 1'b0;
        pri_addr  = 21'h1F00F;
        sec_addr  = {21'h00222, 21'h00100};
        sec_req_t = 2'b11;
        idle_steps(1, "t4_hold");
        pri_req = 1'b0;
        idle_steps(4, "t4_hold");
        mem_ready = 1'b1;
        idle_steps(1, "t4_decide");
        step();
        expect_strobe("t4_pri", 1'b0, 1'b1, 21'h1F00F, 8'h00, 2'd0, 2'b01);
        step();
        expect_strobe("t4_sec", 1'b0, 1'b1, 21'h00222, 8'h00, 2'd2, 2'b11);

        // 5: both ports re-request on every ack; grants must alternate
        sec_req_t = 2'b00;
        exp_g     = 2'd1;
        n_grants  = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            chk("t5_no_we", mem_we, 1'b0);
            if (mem_re === 1'b1) begin
                chk("t5_grant", mem_grant, exp_g);
                if (mem_grant == 2'd1) begin
                    chk("t5_ack0", sec_ack_t[0], sec_req_t[0]);
                    sec_req_t[0] = ~sec_req_t[0];
                end else if (mem_grant == 2'd2) begin
                    chk("t5_ack1", sec_ack_t[1], sec_req_t[1]);
                    sec_req_t[1] = ~sec_req_t[1];
                end
                exp_g = (exp_g == 2'd1) ? 2'd2 : 2'd1;
                n_grants++;
            end
        end
        chk("t5_count", (n_grants >= 6), 1'b1);
        for (int c = 0; c < 10; c++) step();
        chk("t5_drained_ack", sec_ack_t, sec_req_t);

        // 6: reset while a read strobe is high and the other port still pending
        sec_req_t = sec_req_t ^ 2'b11;
        found = 1'b0;
        for (int c = 0; c < 12 && !found; c++) begin
            step();
            if (mem_re === 1'b1) found = 1'b1;
        end
        chk("t6_strobe_seen", found, 1'b1);
        reset = 1'b1;
        #1;
        expect_strobe("t6_reset", 1'b0, 1'b0, 21'h0, 8'h00, 2'd0, 2'b00);
        sec_req_t = 2'b00;
        step();
        step();
        reset = 1'b0;
        idle_steps(8, "t6_idle");
        chk("t6_ack", sec_ack_t, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
